imem_loader: RTL

//   Writer side of the instruction memory that fetch reads. Receives a program image as a

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_loader_byte_packer.sv | 35 +++
 rtl/imem_loader.sv | 98 +++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned CNT_W          = 2;

  typedef logic [WORD_W-1:0] instr_t;
  typedef logic [WORD_W-1:0] addr_t;

  typedef enum logic [1:0] {
    S_HEADER,
    S_PAYLOAD,
    S_DONE,
    S_ERROR
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a little-endian byte stream into 32-bit words; shared by header and payload.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_fire,
  input  logic [BYTE_W-1:0] in_data,
  output logic              word_valid_c,
  output instr_t            word_out_c
);

  localparam int unsigned SHR_W = WORD_W - BYTE_W;

  logic [CNT_W-1:0] byte_cnt;
  logic [SHR_W-1:0] shreg;

  // Byte counter and right-shifting holding register (first byte ends in bits [7:0]).
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt <= '0;
      shreg    <= '0;
    end else if (in_fire) begin
      byte_cnt <= byte_cnt + CNT_W'(1);
      shreg    <= {in_data, shreg[SHR_W-1:BYTE_W]};
    end
  end

  // The 4th byte completes the word in the same cycle it is accepted.
  always_comb begin
    word_valid_c = in_fire && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));
    word_out_c   = {in_data, shreg};
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed program image into instruction memory, then releases the core.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output addr_t             mem_addr,
  output instr_t            mem_wdata,
  output logic              core_hold,
  output logic              load_done,
  output logic              load_err
);

  loader_state_t     state;
  loader_state_t     state_next;
  logic              fire_c;
  logic              word_valid_c;
  instr_t            word_c;
  logic [WORD_W-1:0] n_words;
  logic [WORD_W-1:0] word_cnt;

  assign fire_c = in_valid && in_ready;

  imem_loader_byte_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .in_fire      (fire_c),
    .in_data      (in_data),
    .word_valid_c (word_valid_c),
    .word_out_c   (word_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_HEADER;
    else       state <= state_next;
  end

  // Next state: header decides the path; payload ends one cycle after the N-th write.
  always_comb begin
    state_next = state;
    case (state)
      S_HEADER: begin
        if (word_valid_c) begin
          if (word_c == '0)                         state_next = S_DONE;
          else if (word_c > WORD_W'(MEM_SIZE))      state_next = S_ERROR;
          else                                      state_next = S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (mem_we && ((word_cnt + WORD_W'(1)) == n_words)) state_next = S_DONE;
      end
      default: state_next = state;
    endcase
  end

  // Header latch, write strobe/address/data, and word counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      n_words   <= '0;
      word_cnt  <= '0;
    end else begin
      mem_we <= 1'b0;
      if ((state == S_HEADER) && word_valid_c) n_words <= word_c;
      if ((state == S_PAYLOAD) && word_valid_c) begin
        mem_we    <= 1'b1;
        mem_addr  <= addr_t'(word_cnt << 2);
        mem_wdata <= word_c;
      end
      if (mem_we) word_cnt <= word_cnt + WORD_W'(1);
    end
  end

  // Status outputs follow the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_ready  <= 1'b1;
      core_hold <= 1'b1;
      load_done <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      in_ready  <= (state_next == S_HEADER) || (state_next == S_PAYLOAD);
      core_hold <= (state_next != S_DONE);
      load_done <= (state_next == S_DONE);
      load_err  <= (state_next == S_ERROR);
    end
  end

endmodule
